rf_burst_ctrl: RTL and testbench

Burst access controller placed directly upstream of the 8 x 32-bit register file. It accepts one command at a time (start address, length, direction) and runs a burst of 1-8 beats. Write bursts move a valid/ready data stream into the register file's write port. Read bursts stream the register file's combinational read port out through a registered valid/ready output.

---
 rtl/rf_burst_ctrl_if.sv | 28 ++
 rtl/rf_burst_ctrl.sv | 111 +++++++++++
 tb/tb_rf_burst_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_burst_ctrl_if.sv
// Command, write-stream and read-stream signals of the register-file burst controller.
interface rf_burst_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [2:0]  cmd_addr;
  logic [2:0]  cmd_len;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        rd_ready;
  logic        done;

  // Client side: issues commands, supplies write beats, consumes read beats
  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done
  );

  // Controller side
  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done
  );
endinterface

// File: rtl/rf_burst_ctrl.sv
// Burst access controller in front of an 8 x 32-bit register file.
// Runs 1-8 beat write or read bursts with a modulo-8 wrapping address.
module rf_burst_ctrl (
  input  logic                  clk,
  input  logic                  reset_n,
  rf_burst_ctrl_if.slave        bus,
  output logic [2:0]            rf_wAddr,
  output logic [31:0]           rf_wData,
  output logic                  rf_we,
  output logic [2:0]            rf_rAddr,
  input  logic [31:0]           rf_rData
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t      state, state_d;
  logic [2:0]  cur_addr, cur_addr_d;
  logic [2:0]  beats_left, beats_left_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_last_q, rd_last_d;
  logic        done_q, done_d;

  // Handshake outputs and register-file port passthrough
  assign bus.cmd_ready = (state == IDLE);
  assign bus.wr_ready  = (state == WRITE);
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.done      = done_q;
  assign rf_we         = (state == WRITE) && bus.wr_valid;
  assign rf_wAddr      = cur_addr;
  assign rf_wData      = bus.wr_data;
  assign rf_rAddr      = cur_addr;

  // State and burst registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      cur_addr   <= '0;
      beats_left <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_d;
      cur_addr   <= cur_addr_d;
      beats_left <= beats_left_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_last_q  <= rd_last_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic: command accept, write beats, read slot loading, drain
  always_comb begin
    state_d      = state;
    cur_addr_d   = cur_addr;
    beats_left_d = beats_left;
    rd_valid_d   = rd_valid_q;
    rd_data_d    = rd_data_q;
    rd_last_d    = rd_last_q;
    done_d       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          cur_addr_d   = bus.cmd_addr;
          beats_left_d = bus.cmd_len;
          state_d      = bus.cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (bus.wr_valid) begin
          cur_addr_d = cur_addr + 3'd1;
          if (beats_left == 3'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            beats_left_d = beats_left - 3'd1;
          end
        end
      end
      READ: begin
        // Single output slot: refill whenever it is empty or drained this cycle
        if (!rd_valid_q || bus.rd_ready) begin
          rd_data_d  = rf_rData;
          rd_valid_d = 1'b1;
          rd_last_d  = (beats_left == 3'd0);
          cur_addr_d = cur_addr + 3'd1;
          if (beats_left == 3'd0) begin
            state_d = DRAIN;
          end else begin
            beats_left_d = beats_left - 3'd1;
          end
        end
      end
      DRAIN: begin
        if (rd_valid_q && bus.rd_ready) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rf_burst_ctrl.sv
// Self-checking bench for rf_burst_ctrl with a behavioural register file.
module tb_rf_burst_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  rf_wAddr, rf_rAddr;
  logic [31:0] rf_wData, rf_rData;
  logic        rf_we;

  rf_burst_ctrl_if bus();

  rf_burst_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .rf_wAddr (rf_wAddr),
    .rf_wData (rf_wData),
    .rf_we    (rf_we),
    .rf_rAddr (rf_rAddr),
    .rf_rData (rf_rData)
  );

  always #5 clk = ~clk;

  // Register file (environment): write at edge, combinational read, not reset
  logic [31:0] mem [8];
  always @(posedge clk) if (rf_we) mem[rf_wAddr] <= rf_wData;
  assign rf_rData = mem[rf_rAddr];

  // Expected register-file contents, updated from the beats the bench sends
  logic [31:0] ref_mem [8];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue_cmd(input bit wr, input logic [2:0] addr, input logic [2:0] len, input bit keep);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    #1;
    check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;
    if (!keep) bus.cmd_valid = 1'b0;
  endtask

  // mode: 0 full rate, 1 random gaps, 2 alternating 1,0,1,...
  task automatic write_phase(input logic [2:0] addr, input logic [2:0] len, input logic [31:0] base,
                             input int mode, output int cycles);
    int beat = 0;
    int c = 0;
    bit v;
    logic [2:0] a;
    logic [31:0] wd;
    while (beat <= int'(len) && c < 64) begin
      c++;
      case (mode)
        0: v = 1'b1;
        1: v = ($urandom_range(0, 3) != 0);
        default: v = (c % 2 == 1);
      endcase
      a  = addr + 3'(beat);
      wd = base * 32'(beat + 1);
      bus.wr_valid = v;
      bus.wr_data  = wd;
      #1;
      check("wr_ready", 32'(bus.wr_ready), 32'd1);
      check("rf_we", 32'(rf_we), 32'(v));
      check("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
      check("done_early", 32'(bus.done), 32'd0);
      if (v) begin
        check("rf_wAddr", 32'(rf_wAddr), 32'(a));
        check("rf_wData", rf_wData, wd);
      end
      @(posedge clk); #1;
      if (v) begin
        ref_mem[a] = wd;
        beat++;
      end
    end
    bus.wr_valid = 1'b0;
    if (beat <= int'(len)) check("write_timeout", 32'(beat), 32'(int'(len) + 1));
    c++;
    #1;
    check("wr_done", 32'(bus.done), 32'd1);
    check("wr_done_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("wr_ready_idle", 32'(bus.wr_ready), 32'd0);
    check("rf_we_idle", 32'(rf_we), 32'd0);
    cycles = c;
  endtask

  // mode: 0 rd_ready always high, 1 random, 2 pattern 1,0,0,1,0,0,...
  task automatic read_phase(input logic [2:0] addr, input logic [2:0] len, input int mode, output int cycles);
    int got = 0;
    int c = 0;
    bit r;
    bit pv = 1'b0;
    bit pr = 1'b0;
    logic [31:0] pd = '0;
    logic [2:0] a;
    while (got <= int'(len) && c < 96) begin
      c++;
      case (mode)
        0: r = 1'b1;
        1: r = 1'($urandom_range(0, 1));
        default: r = ((c - 1) % 3 == 0);
      endcase
      bus.rd_ready = r;
      #1;
      check("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
      check("done_early", 32'(bus.done), 32'd0);
      check("rf_we_read", 32'(rf_we), 32'd0);
      if (pv && !pr) begin
        check("rd_valid_hold", 32'(bus.rd_valid), 32'd1);
        check("rd_data_hold", bus.rd_data, pd);
      end
      if (bus.rd_valid && r) begin
        a = addr + 3'(got);
        check("rd_data", bus.rd_data, ref_mem[a]);
        check("rd_last", 32'(bus.rd_last), 32'(got == int'(len)));
        got++;
      end
      pv = bus.rd_valid;
      pr = r;
      pd = bus.rd_data;
      @(posedge clk); #1;
    end
    bus.rd_ready = 1'b0;
    if (got <= int'(len)) check("read_timeout", 32'(got), 32'(int'(len) + 1));
    c++;
    #1;
    check("rd_done", 32'(bus.done), 32'd1);
    check("rd_valid_after", 32'(bus.rd_valid), 32'd0);
    check("rd_last_after", 32'(bus.rd_last), 32'd0);
    check("rd_done_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    cycles = c;
  endtask

  typedef struct {
    bit          wr;
    logic [2:0]  addr;
    logic [2:0]  len;
    logic [31:0] base;
    int          exp_cycles;   // command accept to done cycle
  } vec_t;

  vec_t tbl [6];

  initial begin
    int cyc;
    tbl[0] = '{1'b1, 3'd0, 3'd7, 32'h1111_1111, 9};
    tbl[1] = '{1'b0, 3'd6, 3'd3, 32'h0,          6};
    tbl[2] = '{1'b1, 3'd5, 3'd0, 32'hDEAD_BEEF,  2};
    tbl[3] = '{1'b0, 3'd5, 3'd0, 32'h0,          3};
    tbl[4] = '{1'b0, 3'd0, 3'd7, 32'h0,         10};
    tbl[5] = '{1'b1, 3'd7, 3'd2, 32'h0102_0304,  4};

    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rd_last", 32'(bus.rd_last), 32'd0);
    check("rst_rd_data", bus.rd_data, 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_rf_wAddr", 32'(rf_wAddr), 32'd0);
    check("rst_rf_rAddr", 32'(rf_rAddr), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Full-rate bursts with known latency
    for (int i = 0; i < 6; i++) begin
      issue_cmd(tbl[i].wr, tbl[i].addr, tbl[i].len, 1'b0);
      if (tbl[i].wr) write_phase(tbl[i].addr, tbl[i].len, tbl[i].base, 0, cyc);
      else           read_phase(tbl[i].addr, tbl[i].len, 0, cyc);
      check("burst_latency", 32'(cyc), 32'(tbl[i].exp_cycles));
      if (i == 0) check("fill_reg6", ref_mem[6], 32'h7777_7777);
    end

    // Read with rd_ready stalls: 8 beats, one accepted every third cycle
    issue_cmd(1'b0, 3'd0, 3'd7, 1'b0);
    read_phase(3'd0, 3'd7, 2, cyc);
    check("stall_read_latency", 32'(cyc), 32'd26);

    // Write with wr_valid gaps 1,0,1,0,1 into registers 3..5
    issue_cmd(1'b1, 3'd3, 3'd2, 1'b0);
    write_phase(3'd3, 3'd2, 32'hCAFE_0000, 2, cyc);
    check("gap_write_latency", 32'(cyc), 32'd6);
    for (int i = 0; i < 8; i++) check("regfile_contents", mem[i], ref_mem[i]);

    // Reset during the third beat of an 8-beat read
    issue_cmd(1'b0, 3'd0, 3'd7, 1'b0);
    bus.rd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_read_valid", 32'(bus.rd_valid), 32'd1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.rd_ready = 1'b0;
    #1;
    check("abort_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("abort_rd_last", 32'(bus.rd_last), 32'd0);
    issue_cmd(1'b0, 3'd2, 3'd0, 1'b0);
    read_phase(3'd2, 3'd0, 0, cyc);
    check("post_abort_latency", 32'(cyc), 32'd3);

    // Back-to-back: second command held on cmd_valid, accepted in the done cycle
    issue_cmd(1'b1, 3'd1, 3'd1, 1'b1);
    bus.cmd_write = 1'b0; bus.cmd_addr = 3'd1; bus.cmd_len = 3'd1;
    write_phase(3'd1, 3'd1, 32'hA5A5_0000, 0, cyc);
    check("b2b_write_latency", 32'(cyc), 32'd3);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    read_phase(3'd1, 3'd1, 0, cyc);
    check("b2b_read_latency", 32'(cyc), 32'd4);

    // Randomized bursts with random wr_valid / rd_ready
    for (int i = 0; i < 30; i++) begin
      bit wr;
      logic [2:0] a, l;
      wr = 1'($urandom_range(0, 1));
      a  = 3'($urandom_range(0, 7));
      l  = 3'($urandom_range(0, 7));
      issue_cmd(wr, a, l, 1'b0);
      if (wr) write_phase(a, l, $urandom, 1, cyc);
      else    read_phase(a, l, 1, cyc);
    end
    for (int i = 0; i < 8; i++) check("final_regfile", mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
